// File: rtl/spu_pkg.sv
// Shared types and constants for the even-pipe issue scoreboard.
package spu_pkg;
  localparam int REG_ADDR_W = 7;

  localparam int LAT_SIMPLE = 2;
  localparam int LAT_FP     = 6;
  localparam int LAT_INTMPY = 7;

  typedef logic [0:REG_ADDR_W-1] reg_addr_t;
endpackage

// File: rtl/spu_sb_counter.sv
// One per-register countdown: load wins over decrement, never underflows.
module spu_sb_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt
);
  always_comb begin
    cnt_nxt = cnt;
    if (load)            cnt_nxt = load_val;
    else if (cnt != '0)  cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt_nxt;
  end
endmodule

// File: rtl/spu_issue_scoreboard.sv
// Register-dependency scoreboard for the even-pipe issue point: RAW/WAW holds
// via self-timed per-register countdowns, plus a saturating stall counter.
module spu_issue_scoreboard
  import spu_pkg::*;
#(
  parameter int NUM_REGS    = 128,
  parameter int CNT_W       = 3,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  reg_addr_t              ra_addr,
  input  reg_addr_t              rb_addr,
  input  reg_addr_t              rc_addr,
  input  logic                   ra_used,
  input  logic                   rb_used,
  input  logic                   rc_used,
  input  reg_addr_t              rt_addr,
  input  logic                   reg_write,
  input  logic [CNT_W-1:0]       lat,
  input  logic                   branch_taken,
  output logic                   issue_fire,
  output logic                   stall,
  output logic                   busy_any,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_nxt;
  logic [NUM_REGS-1:0]            load;
  logic [CNT_W-1:0]               lat_m1;
  logic                           reserve;
  logic                           src_hazard;
  logic                           waw_hazard;
  logic                           go;

  assign lat_m1  = lat - 1'b1;
  assign reserve = reg_write && (lat != '0);

  // Sources see the pre-update count, so an instruction never waits on its own rt.
  always_comb begin
    src_hazard = (ra_used && (cnt[ra_addr] != '0)) ||
                 (rb_used && (cnt[rb_addr] != '0)) ||
                 (rc_used && (cnt[rc_addr] != '0));
    waw_hazard = reserve && (cnt[rt_addr] > lat_m1);
  end

  assign go         = reset && issue_valid && !branch_taken;
  assign stall      = go && (src_hazard || waw_hazard);
  assign issue_fire = go && !(src_hazard || waw_hazard);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    assign load[r] = issue_fire && reserve && (rt_addr == reg_addr_t'(r));

    spu_sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (load[r]),
      .load_val (lat_m1),
      .cnt      (cnt[r]),
      .cnt_nxt  (cnt_nxt[r])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_any     <= 1'b0;
      stall_cycles <= '0;
    end else begin
      busy_any <= |cnt_nxt;
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// Directed-vector bench: stimulus queues expected fire/stall, a negedge monitor checks them.
module tb_spu_issue_scoreboard;
  import spu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0;
  reg_addr_t   ra_addr = '0, rb_addr = '0, rc_addr = '0, rt_addr = '0;
  logic        ra_used = 1'b0, rb_used = 1'b0, rc_used = 1'b0;
  logic        reg_write = 1'b0;
  logic [2:0]  lat = '0;
  logic        branch_taken = 1'b0;
  logic        issue_fire, stall, busy_any;
  logic [31:0] stall_cycles;
  logic        s_fire, s_stall, s_busy;
  logic [2:0]  s_cycles;

  spu_issue_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
    .ra_used(ra_used), .rb_used(rb_used), .rc_used(rc_used),
    .rt_addr(rt_addr), .reg_write(reg_write), .lat(lat),
    .branch_taken(branch_taken), .issue_fire(issue_fire), .stall(stall),
    .busy_any(busy_any), .stall_cycles(stall_cycles)
  );

  // Narrow stall counter instance so saturation is reachable in a short run.
  spu_issue_scoreboard #(.STALL_CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
    .ra_used(ra_used), .rb_used(rb_used), .rc_used(rc_used),
    .rt_addr(rt_addr), .reg_write(reg_write), .lat(lat),
    .branch_taken(branch_taken), .issue_fire(s_fire), .stall(s_stall),
    .busy_any(s_busy), .stall_cycles(s_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic fire; logic stall; } exp_t;
  exp_t q[$];
  exp_t e_mon;
  int   checks = 0;
  int   failures = 0;
  int   exp_stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Present one instruction for one cycle and queue its expected outcome.
  task automatic present(input int ra, input int rau, input int rb, input int rbu,
                         input int rc, input int rcu, input int rt, input int wr,
                         input int l, input int br, input logic ef, input logic es);
    issue_valid  = 1'b1;
    ra_addr = 7'(ra); ra_used = rau[0];
    rb_addr = 7'(rb); rb_used = rbu[0];
    rc_addr = 7'(rc); rc_used = rcu[0];
    rt_addr = 7'(rt); reg_write = wr[0];
    lat = 3'(l); branch_taken = br[0];
    q.push_back('{fire: ef, stall: es});
    if (es) exp_stalls++;
    @(posedge clk); #1;
  endtask

  task automatic wr_op(input int rt, input int l, input logic ef, input logic es);
    present(0, 0, 0, 0, 0, 0, rt, 1, l, 0, ef, es);
  endtask

  task automatic rd_op(input int ra, input logic ef, input logic es);
    present(ra, 1, 0, 0, 0, 0, 0, 0, 0, 0, ef, es);
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0; branch_taken = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && issue_valid) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL monitor_underflow actual=empty required=entry");
      end else begin
        e_mon = q.pop_front();
        chk("fire", {31'b0, issue_fire}, {31'b0, e_mon.fire});
        chk("stall", {31'b0, stall}, {31'b0, e_mon.stall});
      end
    end
  end

  initial begin
    // Reset held while a valid reservation is presented.
    issue_valid = 1'b1; rt_addr = 7'd5; reg_write = 1'b1; lat = 3'(LAT_FP);
    @(negedge clk);
    chk("rst_fire", {31'b0, issue_fire}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_busy", {31'b0, busy_any}, 32'd0);
    chk("rst_cycles", stall_cycles, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    wr_op(5, LAT_FP, 1, 0);
    chk("busy_after_res", {31'b0, busy_any}, 32'd1);

    // RAW: reader of r10 waits five cycles behind an fp write.
    wr_op(10, LAT_FP, 1, 0);
    repeat (5) rd_op(10, 0, 1);
    rd_op(10, 1, 0);
    chk("raw_stall_cycles", stall_cycles, 32'd5);

    // Unused colliding source is ignored; a used rc is not.
    wr_op(10, LAT_FP, 1, 0);
    present(11, 1, 10, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    present(0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 1);

    // Source equal to own rt checks only the old count.
    present(50, 1, 0, 0, 0, 0, 50, 1, LAT_FP, 0, 1, 0);
    rd_op(50, 0, 1);

    // WAW: lat-2 write to r20 held until the lat-7 count drops to 1.
    wr_op(20, LAT_INTMPY, 1, 0);
    repeat (5) wr_op(20, LAT_SIMPLE, 0, 1);
    wr_op(20, LAT_SIMPLE, 1, 0);
    rd_op(20, 0, 1);
    rd_op(20, 1, 0);

    // Branch squash: no reservation, and it overrides a hazard stall.
    present(0, 0, 0, 0, 0, 0, 30, 1, LAT_FP, 1, 0, 0);
    rd_op(30, 1, 0);
    wr_op(31, LAT_INTMPY, 1, 0);
    present(31, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    rd_op(31, 0, 1);

    // Load beats decrement: re-fire r40 while its count is 1.
    wr_op(40, 3, 1, 0);
    idle(1);
    wr_op(40, 3, 1, 0);
    rd_op(40, 0, 1);
    rd_op(40, 0, 1);
    rd_op(40, 1, 0);

    // L=1 back-to-back, L=0 and reg_write=0 leave no reservation.
    wr_op(60, 1, 1, 0);
    rd_op(60, 1, 0);
    wr_op(61, 0, 1, 0);
    rd_op(61, 1, 0);
    present(0, 0, 0, 0, 0, 0, 62, 0, LAT_INTMPY, 0, 1, 0);
    rd_op(62, 1, 0);

    // Register 0 behaves like any other.
    wr_op(0, LAT_SIMPLE, 1, 0);
    rd_op(0, 0, 1);
    rd_op(0, 1, 0);

    // busy_any tracks the post-update counts.
    idle(8);
    chk("busy_drained", {31'b0, busy_any}, 32'd0);
    wr_op(70, LAT_SIMPLE, 1, 0);
    chk("busy_lat2", {31'b0, busy_any}, 32'd1);
    idle(1);
    chk("busy_lat2_done", {31'b0, busy_any}, 32'd0);

    chk("stall_total", stall_cycles, 32'(exp_stalls));
    chk("stall_saturated", {29'b0, s_cycles}, (exp_stalls > 7) ? 32'd7 : 32'(exp_stalls));

    // Mid-operation reset drops reservations at once.
    wr_op(80, LAT_INTMPY, 1, 0);
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy_any}, 32'd0);
    chk("midrst_cycles", stall_cycles, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    rd_op(80, 1, 0);
    wr_op(80, LAT_SIMPLE, 1, 0);
    idle(2);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
endmodule
